imm_gen_pipe: RTL and testbench
===============================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64 only.
REQ-002 Parameter TAG_W, default 5, width of the sideband tag carried with each instruction.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  instruction offered.
REQ-006 in_ready  output  1  block can accept; registered, never combinationally dependent on out_ready.
REQ-007 in_instr  input  32  full instruction word.
REQ-008 in_immsrc  input  3  format select: 000 I, 001 S, 101 B, 010 U, 110 J, 011 Z (CSR zimm), 100 SH (shift amount), 111 AUTO.
REQ-009 in_tag  input  TAG_W  opaque sideband.
REQ-010 flush  input  1  discard all buffered entries.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts.
REQ-013 out_imm  output  XLEN  extended immediate.
REQ-014 out_fmt  output  3  resolved format code; never 111.
REQ-015 out_illegal  output  1  AUTO could not classify the opcode.
REQ-016 out_tag  output  TAG_W  in_tag of the same entry.

Function
REQ-017 Extraction from in_instr: I = sext(instr[31:20]); S = sext({instr[31:25],instr[11:7]}); B = sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}); J = sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}); U = sext({instr[31:12],12'b0}) to XLEN; Z = zext(instr[19:15]); SH = zext(instr[25:20]) when XLEN=64, zext(instr[24:20]) when XLEN=32.
REQ-018 Sign extension replicates instr[31] up to bit XLEN-1 in all signed formats.
REQ-019 AUTO maps opcode[6:0]: 0000011, 1100111 -> I; 0010011 -> SH if funct3 is 001 or 101, else I; 0100011 -> S; 1100011 -> B; 0110111, 0010111 -> U; 1101111 -> J; 1110011 -> Z if funct3[2]=1, else I; anything else -> illegal.
REQ-020 Illegal entry: out_illegal=1, out_imm=0, out_fmt=000; entry still flows through the handshake.
REQ-021 Explicit (non-AUTO) select never sets out_illegal.
REQ-022 Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
REQ-023 Latency: an entry accepted in cycle N is presented with out_valid=1 in cycle N+1 when the output stage is empty or drains in cycle N.
REQ-024 Storage: one output register plus one skid register; capacity 2; strict FIFO order.
REQ-025 in_ready = 1 when skid is empty; 0 when skid holds an entry.
REQ-026 When the output stage stalls and a new entry is accepted, the new entry goes to skid; skid moves to the output register on the next transfer out.
REQ-027 Simultaneous in and out transfer with skid empty: the output register loads the new entry; out_valid remains 1.
REQ-028 Output fields hold stable while out_valid=1 and out_ready=0.
REQ-029 flush=1: both entries are invalidated at the clock edge; an in transfer in the same cycle is dropped; out_valid=0 and in_ready=1 the next cycle.
REQ-030 flush has priority over all in and out transfers.

Reset
REQ-031 rst=1 at a clock edge: out_valid=0, skid empty, in_ready=1, out_imm=0, out_fmt=000, out_illegal=0, out_tag=0.
REQ-032 Reset during a stall discards both entries; no partial entry emerges afterwards.
REQ-033 rst has priority over flush and all handshakes.

Structure
REQ-034 Package imm_pkg holds: the format enum (the 3-bit codes above), the opcode localparams used by AUTO, and the result struct (imm, fmt, illegal).
REQ-035 Combinational sub-module imm_extract (instr, immsrc -> imm, fmt, illegal), parametrised by XLEN; imm_gen_pipe holds only the handshake and storage around it.
REQ-036 An XLEN value other than 32 or 64 shall cause an elaboration-time error.

Verification
REQ-037 XLEN=32, immsrc=000, instr=0xFFF00093 -> out_imm=0xFFFFFFFF, out_fmt=000, one cycle after acceptance.
REQ-038 immsrc=101, instr=0xFE000EE3 -> out_imm=0xFFFFFFFC; same instr with immsrc=111 -> identical result, out_fmt=101.
REQ-039 XLEN=64, AUTO, instr=0x123450B7 -> out_imm=0x0000000012345000; instr=0x80000037 -> out_imm=0xFFFFFFFF80000000.
REQ-040 AUTO, instr=0x0000007F, tag=3 -> out_illegal=1, out_imm=0, out_tag=3.
REQ-041 Hold out_ready=0 and push tags 1, 2 -> in_ready=0 after the second push; release out_ready -> tags 1 then 2 emerge on consecutive cycles, in_ready=1 again.
REQ-042 With 2 entries buffered, assert flush together with in_valid -> next cycle out_valid=0, in_ready=1, and no entry emerges later.

Source files
------------

// File: rtl/imm_pkg.sv
// Immediate generator shared types: format codes, AUTO opcodes, result bundle.
// Imported by the extractor, the pipeline wrapper and the bench.
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_I    = 3'b000,
        FMT_S    = 3'b001,
        FMT_U    = 3'b010,
        FMT_Z    = 3'b011,
        FMT_SH   = 3'b100,
        FMT_B    = 3'b101,
        FMT_J    = 3'b110,
        FMT_AUTO = 3'b111
    } fmt_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam int IMM_MAXW = 64;

    typedef struct packed {
        logic [IMM_MAXW-1:0] imm;
        fmt_e                fmt;
        logic                illegal;
    } imm_res_t;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction and AUTO format classification.
// Unclassifiable opcodes in AUTO mode yield imm=0, fmt=I, illegal=1.
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      immsrc,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt,
    output logic            illegal
);

    logic [6:0]      op;
    logic [2:0]      f3;
    logic            is_auto;
    fmt_e            auto_fmt;
    logic            auto_bad;
    fmt_e            sel;
    logic [XLEN-1:0] raw;

    assign op      = instr[6:0];
    assign f3      = instr[14:12];
    assign is_auto = (immsrc == FMT_AUTO);

    always_comb begin
        auto_fmt = FMT_I;
        auto_bad = 1'b0;
        unique case (1'b1)
            (op == OP_LOAD), (op == OP_JALR):
                auto_fmt = FMT_I;
            (op == OP_IMM):
                auto_fmt = (f3 == 3'b001 || f3 == 3'b101) ? FMT_SH : FMT_I;
            (op == OP_STORE):
                auto_fmt = FMT_S;
            (op == OP_BRANCH):
                auto_fmt = FMT_B;
            (op == OP_LUI), (op == OP_AUIPC):
                auto_fmt = FMT_U;
            (op == OP_JAL):
                auto_fmt = FMT_J;
            (op == OP_SYSTEM):
                auto_fmt = f3[2] ? FMT_Z : FMT_I;
            default:
                auto_bad = 1'b1;
        endcase
    end

    assign sel = is_auto ? auto_fmt : fmt_e'(immsrc);

    always_comb begin
        raw = '0;
        case (sel)
            FMT_I:  raw = {{(XLEN-12){instr[31]}}, instr[31:20]};
            FMT_S:  raw = {{(XLEN-12){instr[31]}}, instr[31:25],
                           instr[11:7]};
            FMT_B:  raw = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                           instr[30:25], instr[11:8], 1'b0};
            FMT_J:  raw = {{(XLEN-21){instr[31]}}, instr[31],
                           instr[19:12], instr[20], instr[30:21], 1'b0};
            FMT_U:  raw = {{(XLEN-31){instr[31]}}, instr[30:12], 12'b0};
            FMT_Z:  raw = {{(XLEN-5){1'b0}}, instr[19:15]};
            FMT_SH: raw = (XLEN == 64)
                        ? {{(XLEN-6){1'b0}}, instr[25:20]}
                        : {{(XLEN-5){1'b0}}, instr[24:20]};
            default: raw = '0;
        endcase
    end

    assign illegal = is_auto && auto_bad;
    assign imm     = illegal ? '0 : raw;
    assign fmt     = illegal ? FMT_I : sel;

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator wrapped in a two-entry valid/ready stage
// (output register plus skid register, in_ready is a flop).
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_immsrc,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        fmt_e             fmt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [XLEN-1:0] x_imm;
    fmt_e            x_fmt;
    logic            x_ill;
    entry_t          new_e;
    entry_t          out_q;
    entry_t          skid_q;
    logic            ov_q;
    logic            sv_q;
    logic            rdy_q;
    logic            take_in;
    logic            take_out;
    logic            load_out;

    imm_extract #(
        .XLEN(XLEN)
    ) u_extract (
        .instr  (in_instr),
        .immsrc (in_immsrc),
        .imm    (x_imm),
        .fmt    (x_fmt),
        .illegal(x_ill)
    );

    assign new_e    = '{imm: x_imm, fmt: x_fmt, illegal: x_ill, tag: in_tag};
    assign take_in  = in_valid && rdy_q;
    assign take_out = ov_q && out_ready;
    assign load_out = !ov_q || take_out;

    // skid only fills while the output register is stalled, so sv_q implies ov_q
    always_ff @(posedge clk) begin
        if (rst) begin
            ov_q   <= 1'b0;
            sv_q   <= 1'b0;
            rdy_q  <= 1'b1;
            out_q  <= '0;
            skid_q <= '0;
        end else if (flush) begin
            ov_q  <= 1'b0;
            sv_q  <= 1'b0;
            rdy_q <= 1'b1;
        end else if (load_out) begin
            if (sv_q) begin
                out_q <= skid_q;
                ov_q  <= 1'b1;
                sv_q  <= 1'b0;
                rdy_q <= 1'b1;
            end else if (take_in) begin
                out_q <= new_e;
                ov_q  <= 1'b1;
            end else begin
                ov_q <= 1'b0;
            end
        end else if (take_in) begin
            skid_q <= new_e;
            sv_q   <= 1'b1;
            rdy_q  <= 1'b0;
        end
    end

    assign in_ready    = rdy_q;
    assign out_valid   = ov_q;
    assign out_imm     = out_q.imm;
    assign out_fmt     = out_q.fmt;
    assign out_illegal = out_q.illegal;
    assign out_tag     = out_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share
// stimulus; expected values are hand-computed constants.
module tb_imm_gen_pipe;
    import imm_pkg::*;

    localparam int TW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [31:0]   in_instr;
    logic [2:0]    in_immsrc;
    logic [TW-1:0] in_tag;
    logic          flush;
    logic          out_ready;

    logic          rdy32, ov32, ill32;
    logic [31:0]   imm32;
    logic [2:0]    fmt32;
    logic [TW-1:0] tag32;
    logic          rdy64, ov64, ill64;
    logic [63:0]   imm64;
    logic [2:0]    fmt64;
    logic [TW-1:0] tag64;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(TW)) dut32 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(rdy32),
        .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag),
        .flush(flush),
        .out_valid(ov32), .out_ready(out_ready),
        .out_imm(imm32), .out_fmt(fmt32),
        .out_illegal(ill32), .out_tag(tag32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(TW)) dut64 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(rdy64),
        .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag),
        .flush(flush),
        .out_valid(ov64), .out_ready(out_ready),
        .out_imm(imm64), .out_fmt(fmt64),
        .out_illegal(ill64), .out_tag(tag64)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  src;
        logic [31:0] imm32;
        imm_res_t    r64;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [31:0] instr,
                                input logic [2:0] src,
                                input logic [31:0] e32,
                                input logic [63:0] e64,
                                input fmt_e f, input logic ill);
        vec_t v;
        v.instr = instr;
        v.src   = src;
        v.imm32 = e32;
        v.r64   = '{imm: e64, fmt: f, illegal: ill};
        vecs.push_back(v);
    endfunction

    task automatic push_one(input logic [31:0] instr, input logic [2:0] src,
                            input logic [TW-1:0] tag);
        in_valid  = 1'b1;
        in_instr  = instr;
        in_immsrc = src;
        in_tag    = tag;
        step();
        in_valid  = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_immsrc = '0;
        in_tag    = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        chk("rst_ov",  ov32, 0);
        chk("rst_rdy", rdy32, 1);
        chk("rst_imm", imm32, 0);
        chk("rst_fmt", fmt32, 0);
        chk("rst_ill", ill32, 0);
        chk("rst_tag", tag32, 0);
        chk("rst_ov64", ov64, 0);
        rst = 1'b0;
        step();

        add(32'hFFF00093, 3'b000, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, FMT_I, 0);
        add(32'hFE000EE3, 3'b101, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, FMT_B, 0);
        add(32'hFE000EE3, 3'b111, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, FMT_B, 0);
        add(32'h123450B7, 3'b111, 32'h12345000, 64'h0000000012345000, FMT_U, 0);
        add(32'h80000037, 3'b111, 32'h80000000, 64'hFFFFFFFF80000000, FMT_U, 0);
        add(32'h0000007F, 3'b111, 32'h0, 64'h0, FMT_I, 1);
        add(32'h0000007F, 3'b000, 32'h0, 64'h0, FMT_I, 0);
        add(32'h00112623, 3'b111, 32'h0000000C, 64'hC, FMT_S, 0);
        add(32'hFE112E23, 3'b111, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, FMT_S, 0);
        add(32'h0080006F, 3'b111, 32'h00000008, 64'h8, FMT_J, 0);
        add(32'hFFDFF06F, 3'b111, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, FMT_J, 0);
        add(32'h03F11093, 3'b111, 32'h0000001F, 64'h3F, FMT_SH, 0);
        add(32'h340FD073, 3'b111, 32'h0000001F, 64'h1F, FMT_Z, 0);
        add(32'h340FD073, 3'b011, 32'h0000001F, 64'h1F, FMT_Z, 0);
        add(32'h34011073, 3'b111, 32'h00000340, 64'h340, FMT_I, 0);
        add(32'hFFFFF013, 3'b010, 32'hFFFFF000, 64'hFFFFFFFFFFFFF000, FMT_U, 0);

        foreach (vecs[i]) begin
            logic [TW-1:0] t;
            string         n;
            t = TW'(i + 3);
            n = $sformatf("v%0d", i);
            push_one(vecs[i].instr, vecs[i].src, t);
            chk({n, "_ov"},    ov32, 1);
            chk({n, "_imm32"}, imm32, vecs[i].imm32);
            chk({n, "_fmt32"}, fmt32, vecs[i].r64.fmt);
            chk({n, "_ill32"}, ill32, vecs[i].r64.illegal);
            chk({n, "_tag32"}, tag32, t);
            chk({n, "_imm64"}, imm64, vecs[i].r64.imm);
            chk({n, "_fmt64"}, fmt64, vecs[i].r64.fmt);
            chk({n, "_ill64"}, ill64, vecs[i].r64.illegal);
            step();
            chk({n, "_drain"}, ov32, 0);
        end

        // back-to-back with the consumer ready: output reloads each cycle
        in_valid  = 1'b1;
        in_instr  = 32'hFFF00093;
        in_immsrc = 3'b000;
        in_tag    = 5'd10;
        step();
        chk("bb_tag0", tag32, 10);
        in_tag = 5'd11;
        step();
        chk("bb_ov1",  ov32, 1);
        chk("bb_tag1", tag32, 11);
        chk("bb_rdy1", rdy32, 1);
        in_valid = 1'b0;
        step();
        chk("bb_ov2", ov32, 0);

        // stall: tags 1 then 2 buffered, then released in order
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_tag    = 5'd1;
        step();
        chk("sk_rdy1", rdy32, 1);
        in_tag = 5'd2;
        step();
        in_valid = 1'b0;
        chk("sk_rdy2", rdy32, 0);
        chk("sk_tag1", tag32, 1);
        step();
        chk("sk_hold_ov",  ov32, 1);
        chk("sk_hold_tag", tag32, 1);
        chk("sk_hold_imm", imm32, 32'hFFFFFFFF);
        out_ready = 1'b1;
        step();
        chk("sk_out2_ov",  ov32, 1);
        chk("sk_out2_tag", tag32, 2);
        chk("sk_out2_rdy", rdy32, 1);
        step();
        chk("sk_empty", ov32, 0);

        // flush with two buffered and a concurrent offer
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_tag    = 5'd4;
        step();
        in_tag = 5'd5;
        step();
        chk("fl_full", rdy32, 0);
        in_tag = 5'd7;
        flush  = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_ov",  ov32, 0);
        chk("fl_rdy", rdy32, 1);
        out_ready = 1'b1;
        step();
        step();
        step();
        chk("fl_none", ov32, 0);

        // reset in the middle of a stall
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_tag    = 5'd8;
        step();
        in_tag = 5'd9;
        step();
        in_valid = 1'b0;
        rst      = 1'b1;
        step();
        rst = 1'b0;
        chk("rs_ov",  ov32, 0);
        chk("rs_rdy", rdy32, 1);
        chk("rs_tag", tag32, 0);
        out_ready = 1'b1;
        step();
        step();
        chk("rs_none", ov32, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
